// File: rtl/rgb_mixer_pkg.sv
// Shared RGB mixer types and constants: channel count, level width, scan states, gamma map.
// Combinational helpers only; no latency or backpressure of their own.
package rgb_mixer_pkg;

    localparam int NUM_CH  = 3;
    localparam int LEVEL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN0 = 2'd1,
        SCAN1 = 2'd2,
        SCAN2 = 2'd3
    } scan_state_t;

    // (l*l + l) >> 8 keeps both endpoints exact: 0 -> 0, 255 -> 255.
    function automatic logic [LEVEL_W-1:0] gamma_map(input logic [LEVEL_W-1:0] lvl);
        logic [15:0] sq;
        sq = 16'(lvl) * 16'(lvl) + 16'(lvl);
        return sq[15:8];
    endfunction

endpackage

// File: rtl/fade_tick_gen.sv
// Fade tick prescaler: counts 0..TICK_DIV-1, combinational tick at the last count.
// freeze holds the count and suppresses the tick; counting resumes from the held value.
module fade_tick_gen #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic freeze,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!freeze) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = !freeze && (count == LAST);

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Ramps three PWM duties toward encoder targets by <= STEP per tick, round-robin one channel per cycle.
// Duty lags its level by one cycle; no backpressure. Optional gamma duty map via RGB_FADE_GAMMA_EN.
module rgb_fade_ctrl
    import rgb_mixer_pkg::*;
#(
    parameter int TICK_DIV = 1024,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] target0,
    input  logic [7:0] target1,
    input  logic [7:0] target2,
    input  logic       freeze,
    output logic [7:0] duty0,
    output logic [7:0] duty1,
    output logic [7:0] duty2,
    output logic       busy,
    output logic       settled
);

    localparam logic [LEVEL_W:0] STEP9 = (LEVEL_W+1)'(STEP);

    logic [LEVEL_W-1:0] level  [NUM_CH];
    logic [LEVEL_W-1:0] target [NUM_CH];

    scan_state_t state, state_next;
    logic        tick;
    logic [1:0]  sel;
    logic        scan_en;

    logic [LEVEL_W-1:0] cur, tgt, nxt;
    logic [LEVEL_W:0]   diff, step_amt;
    logic               ch_changed;
    logic               changed_acc;
    logic               all_eq_post;
    logic               any_neq;

    assign target[0] = target0;
    assign target[1] = target1;
    assign target[2] = target2;

    fade_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .freeze (freeze),
        .tick   (tick)
    );

    always_comb begin
        state_next = state;
        sel        = 2'd0;
        scan_en    = 1'b0;
        case (state)
            IDLE:  if (tick) state_next = SCAN0;
            SCAN0: begin sel = 2'd0; scan_en = 1'b1; state_next = SCAN1; end
            SCAN1: begin sel = 2'd1; scan_en = 1'b1; state_next = SCAN2; end
            SCAN2: begin sel = 2'd2; scan_en = 1'b1; state_next = IDLE;  end
            default: state_next = IDLE;
        endcase
    end

    // Shared step/clamp datapath; the 9-bit difference cannot wrap.
    always_comb begin
        cur      = level[sel];
        tgt      = target[sel];
        diff     = '0;
        step_amt = '0;
        nxt      = cur;
        if (cur < tgt) begin
            diff     = {1'b0, tgt} - {1'b0, cur};
            step_amt = (diff > STEP9) ? STEP9 : diff;
            nxt      = cur + step_amt[LEVEL_W-1:0];
        end else if (cur > tgt) begin
            diff     = {1'b0, cur} - {1'b0, tgt};
            step_amt = (diff > STEP9) ? STEP9 : diff;
            nxt      = cur - step_amt[LEVEL_W-1:0];
        end
        ch_changed = scan_en && (nxt != cur);
    end

    // Settle test uses the level values as they will be after this cycle's update.
    always_comb begin
        all_eq_post = 1'b1;
        any_neq     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (((scan_en && (sel == 2'(i))) ? nxt : level[i]) != target[i]) begin
                all_eq_post = 1'b0;
            end
            if (level[i] != target[i]) begin
                any_neq = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            changed_acc <= 1'b0;
            settled     <= 1'b0;
            busy        <= 1'b0;
            duty0       <= '0;
            duty1       <= '0;
            duty2       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                level[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (scan_en) begin
                level[sel] <= nxt;
            end
            if (state == SCAN0) begin
                changed_acc <= ch_changed;
            end else if (scan_en) begin
                changed_acc <= changed_acc | ch_changed;
            end
            settled <= (state == SCAN2) && all_eq_post && (changed_acc || ch_changed);
            busy    <= any_neq;
`ifdef RGB_FADE_GAMMA_EN
            duty0 <= gamma_map(level[0]);
            duty1 <= gamma_map(level[1]);
            duty2 <= gamma_map(level[2]);
`else
            duty0 <= level[0];
            duty1 <= level[1];
            duty2 <= level[2];
`endif
        end
    end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Directed bench for rgb_fade_ctrl with TICK_DIV=4; STEP=16 (STEP=128 and gamma checks when RGB_FADE_GAMMA_EN is defined).
module tb_rgb_fade_ctrl;

    localparam int TICK_DIV_P = 4;
`ifdef RGB_FADE_GAMMA_EN
    localparam int STEP_P = 128;
`else
    localparam int STEP_P = 16;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] target0, target1, target2;
    logic       freeze;
    logic [7:0] duty0, duty1, duty2;
    logic       busy, settled;

    int checks;
    int failures;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int settled_cnt, settled_cyc, busy_cnt, last1_cyc;

    rgb_fade_ctrl #(.TICK_DIV(TICK_DIV_P), .STEP(STEP_P)) dut (
        .clk     (clk),
        .reset   (reset),
        .target0 (target0),
        .target1 (target1),
        .target2 (target2),
        .freeze  (freeze),
        .duty0   (duty0),
        .duty1   (duty1),
        .duty2   (duty2),
        .busy    (busy),
        .settled (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_obs();
        q0.delete();
        q1.delete();
        q2.delete();
        settled_cnt = 0;
        settled_cyc = -1;
        busy_cnt    = 0;
        last1_cyc   = -1;
    endtask

    // Records each distinct duty value seen, plus settled/busy activity, over n cycles.
    task automatic observe(input int n);
        logic [7:0] p0, p1, p2;
        p0 = duty0; p1 = duty1; p2 = duty2;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (duty0 !== p0) begin q0.push_back(duty0); p0 = duty0; end
            if (duty1 !== p1) begin q1.push_back(duty1); p1 = duty1; last1_cyc = c; end
            if (duty2 !== p2) begin q2.push_back(duty2); p2 = duty2; end
            if (settled === 1'b1) begin settled_cnt++; settled_cyc = c; end
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; freeze = 1'b0;
        target0 = 8'd0; target1 = 8'd0; target2 = 8'd0;
        repeat (2) @(negedge clk);
        checks++; if ({duty0, duty1, duty2} !== 24'd0) begin failures++;
            $display("FAIL reset_duty: got %0d/%0d/%0d want 0/0/0", duty0, duty1, duty2); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (settled !== 1'b0) begin failures++;
            $display("FAIL reset_settled: got %b want 0", settled); end
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_ramp_up();
        clear_obs();
        target0 = 8'd48;
        observe(40);
        checks++; if (q0.size() != 3 || q0[0] !== 8'd16 || q0[1] !== 8'd32 || q0[2] !== 8'd48) begin failures++;
            $display("FAIL ramp_up_seq: got n=%0d %0d,%0d,%0d want 16,32,48", q0.size(), q0[0], q0[1], q0[2]); end
        checks++; if (q1.size() != 0 || q2.size() != 0) begin failures++;
            $display("FAIL ramp_up_others: got %0d/%0d changes want 0/0", q1.size(), q2.size()); end
        checks++; if (settled_cnt != 1) begin failures++;
            $display("FAIL ramp_up_settled: got %0d pulses want 1", settled_cnt); end
        checks++; if (busy_cnt == 0) begin failures++;
            $display("FAIL ramp_up_busy_seen: got %0d busy cycles want >0", busy_cnt); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL ramp_up_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_clamp();
        clear_obs();
        target1 = 8'd40;
        observe(40);
        checks++; if (q1.size() != 3 || q1[0] !== 8'd16 || q1[1] !== 8'd32 || q1[2] !== 8'd40) begin failures++;
            $display("FAIL clamp_seq: got n=%0d %0d,%0d,%0d want 16,32,40", q1.size(), q1[0], q1[1], q1[2]); end
        checks++; if (q0.size() != 0) begin failures++;
            $display("FAIL clamp_ch0_stable: got %0d changes want 0", q0.size()); end
        checks++; if (settled_cnt != 1) begin failures++;
            $display("FAIL clamp_settled: got %0d pulses want 1", settled_cnt); end
        // settled and the final duty1 value become visible in the same cycle (T+4).
        checks++; if (settled_cyc != last1_cyc) begin failures++;
            $display("FAIL clamp_settled_cycle: got %0d want %0d", settled_cyc, last1_cyc); end
    endtask

    task automatic test_ramp_down();
        clear_obs();
        target2 = 8'd48;
        observe(40);
        clear_obs();
        target2 = 8'd0;
        observe(40);
        checks++; if (q2.size() != 3 || q2[0] !== 8'd32 || q2[1] !== 8'd16 || q2[2] !== 8'd0) begin failures++;
            $display("FAIL ramp_down_seq: got n=%0d %0d,%0d,%0d want 32,16,0", q2.size(), q2[0], q2[1], q2[2]); end
        checks++; if (settled_cnt != 1) begin failures++;
            $display("FAIL ramp_down_settled: got %0d pulses want 1", settled_cnt); end
    endtask

    task automatic test_freeze();
        int k;
        target0 = 8'd0;
        k = 0;
        while (duty0 === 8'd48 && k < 12) begin @(negedge clk); k++; end
        checks++; if (duty0 !== 8'd32) begin failures++;
            $display("FAIL freeze_first_step: got %0d want 32", duty0); end
        freeze = 1'b1;
        clear_obs();
        observe(20);
        checks++; if (q0.size() != 0) begin failures++;
            $display("FAIL freeze_hold: got %0d duty0 changes want 0", q0.size()); end
        checks++; if (settled_cnt != 0) begin failures++;
            $display("FAIL freeze_settled: got %0d pulses want 0", settled_cnt); end
        checks++; if (busy_cnt != 20) begin failures++;
            $display("FAIL freeze_busy: got %0d busy cycles want 20", busy_cnt); end
        freeze = 1'b0;
        k = 0;
        while (duty0 === 8'd32 && k < 20) begin @(negedge clk); k++; end
        checks++; if (k > TICK_DIV_P + 3) begin failures++;
            $display("FAIL freeze_resume_latency: got %0d cycles want <=%0d", k, TICK_DIV_P + 3); end
        checks++; if (duty0 !== 8'd16) begin failures++;
            $display("FAIL freeze_resume_value: got %0d want 16", duty0); end
        clear_obs();
        observe(20);
        checks++; if (q0.size() != 1 || q0[0] !== 8'd0) begin failures++;
            $display("FAIL freeze_finish: got n=%0d %0d want 0", q0.size(), q0[0]); end
        checks++; if (settled_cnt != 1) begin failures++;
            $display("FAIL freeze_finish_settled: got %0d pulses want 1", settled_cnt); end
    endtask

    task automatic test_reset_mid_ramp();
        int k;
        target0 = 8'd255;
        k = 0;
        while (duty0 === 8'd0 && k < 12) begin @(negedge clk); k++; end
        checks++; if (duty0 !== 8'd16) begin failures++;
            $display("FAIL midreset_pre: got %0d want 16", duty0); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({duty0, duty1, duty2} !== 24'd0) begin failures++;
            $display("FAIL midreset_duty: got %0d/%0d/%0d want 0/0/0", duty0, duty1, duty2); end
        checks++; if (busy !== 1'b0 || settled !== 1'b0) begin failures++;
            $display("FAIL midreset_flags: got busy=%b settled=%b want 0/0", busy, settled); end
        target0 = 8'd0; target1 = 8'd0; target2 = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        observe(12);
        checks++; if ({duty0, duty1, duty2} !== 24'd0 || busy !== 1'b0) begin failures++;
            $display("FAIL midreset_after: got %0d/%0d/%0d busy=%b want 0/0/0 busy=0", duty0, duty1, duty2, busy); end
    endtask

`ifdef RGB_FADE_GAMMA_EN
    task automatic test_gamma();
        clear_obs();
        target0 = 8'd255;
        observe(40);
        checks++; if (q0.size() != 2 || q0[0] !== 8'd64) begin failures++;
            $display("FAIL gamma_mid: got n=%0d %0d want 64", q0.size(), q0[0]); end
        checks++; if (duty0 !== 8'd255) begin failures++;
            $display("FAIL gamma_top: got %0d want 255", duty0); end
        checks++; if (settled_cnt != 1) begin failures++;
            $display("FAIL gamma_settled: got %0d pulses want 1", settled_cnt); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        freeze   = 1'b0;
        target0  = 8'd0;
        target1  = 8'd0;
        target2  = 8'd0;
        clear_obs();
        test_reset();
`ifdef RGB_FADE_GAMMA_EN
        test_gamma();
`else
        test_ramp_up();
        test_clamp();
        test_ramp_down();
        test_freeze();
        test_reset_mid_ramp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
